wb_write_arbiter: RTL and testbench

//  Write-side driver of the register file's single write port (regwrite/rd/write_data).
//  - Merges single-cycle ALU results with results from long-latency units (LSU/MUL).
//  - Long-latency results are buffered in an in-order FIFO.
//  - Publishes a pending-write mask so issue logic can stall on outstanding destinations.
//  - Sits at the end of the WB stage; its outputs connect directly to the register file.

---
 rtl/wb_write_arbiter_if.sv | 31 +++
 rtl/wb_write_arbiter.sv | 113 +++++++++++
 tb/tb_wb_write_arbiter.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/wb_write_arbiter_if.sv
// Handshake and register-file write bundle for wb_write_arbiter.
// master = producers/register file side, slave = the arbiter.
interface wb_write_arbiter_if #(
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic          alu_valid;
  logic [4:0]    alu_rd;
  logic [31:0]   alu_data;
  logic          alu_ready;
  logic          mem_valid;
  logic [4:0]    mem_rd;
  logic [31:0]   mem_data;
  logic          mem_ready;
  logic          regwrite;
  logic [4:0]    rd;
  logic [31:0]   write_data;
  logic [CW-1:0] fifo_count;
  logic [31:0]   pend_mask;

  modport master (
    output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
    input  alu_ready, mem_ready, regwrite, rd, write_data, fifo_count, pend_mask
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
    output alu_ready, mem_ready, regwrite, rd, write_data, fifo_count, pend_mask
  );
endinterface

// File: rtl/wb_write_arbiter.sv
// Register-file write port arbiter: single-cycle ALU results take priority over an
// in-order FIFO of long-latency results, with a starvation limit and pending-write mask.
module wb_write_arbiter #(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic              clk,
  input  logic              reset,
  wb_write_arbiter_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

  logic [4:0]       r_q_rd   [DEPTH];
  logic [31:0]      r_q_data [DEPTH];
  logic [DEPTH-1:0] r_vld;
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic [SW-1:0]    r_sc;
  logic             r_regwrite;
  logic [4:0]       r_rd;
  logic [31:0]      r_write_data;

  logic             w_fifo_nonempty;
  logic             w_mem_ready;
  logic             w_alu_ready;
  logic             w_alu_win;
  logic             w_deq;
  logic             w_enq;
  logic [31:0]      w_pend;

  assign w_fifo_nonempty = (r_count != '0);
  assign w_mem_ready     = (r_count != CW'(DEPTH));
  assign w_alu_ready     = !((r_sc == SW'(STARVE_LIMIT)) && w_fifo_nonempty);
  assign w_alu_win       = bus.alu_valid && w_alu_ready;
  assign w_deq           = !w_alu_win && w_fifo_nonempty;
  // rd==0 results complete the handshake but are never stored
  assign w_enq           = bus.mem_valid && w_mem_ready && (bus.mem_rd != '0);

  always_comb begin
    w_pend = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (r_vld[i]) w_pend[r_q_rd[i]] = 1'b1;
    end
    w_pend[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_q_rd[r_wptr]   <= bus.mem_rd;
      r_q_data[r_wptr] <= bus.mem_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vld   <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      // Clear before set: a same-cycle enqueue can never target the slot being
      // dequeued unless the FIFO is full, which blocks the enqueue.
      if (w_deq) begin
        r_vld[r_rptr] <= 1'b0;
        r_rptr        <= r_rptr + AW'(1);
      end
      if (w_enq) begin
        r_vld[r_wptr] <= 1'b1;
        r_wptr        <= r_wptr + AW'(1);
      end
      r_count <= r_count + CW'(w_enq) - CW'(w_deq);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sc <= '0;
    end else if (!w_fifo_nonempty || w_deq) begin
      r_sc <= '0;
    end else if (w_alu_win && (r_sc != SW'(STARVE_LIMIT))) begin
      r_sc <= r_sc + SW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_regwrite   <= 1'b0;
      r_rd         <= '0;
      r_write_data <= '0;
    end else if (w_alu_win) begin
      r_regwrite   <= (bus.alu_rd != '0);
      r_rd         <= bus.alu_rd;
      r_write_data <= bus.alu_data;
    end else if (w_deq) begin
      r_regwrite   <= (r_q_rd[r_rptr] != '0);
      r_rd         <= r_q_rd[r_rptr];
      r_write_data <= r_q_data[r_rptr];
    end else begin
      r_regwrite   <= 1'b0;
    end
  end

  assign bus.alu_ready  = w_alu_ready;
  assign bus.mem_ready  = w_mem_ready;
  assign bus.regwrite   = r_regwrite;
  assign bus.rd         = r_rd;
  assign bus.write_data = r_write_data;
  assign bus.fifo_count = r_count;
  assign bus.pend_mask  = w_pend;
endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed bench for wb_write_arbiter: stimulus pushes expected register writes
// (cycle, rd, data) into a queue; a negedge monitor pops and compares every write.
module tb_wb_write_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int unsigned cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int unsigned cyc;
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;
  wr_t exp_q[$];

  wb_write_arbiter_if #(.DEPTH(4)) bus ();

  wb_write_arbiter #(.DEPTH(4), .STARVE_LIMIT(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int unsigned c, input logic [4:0] r, input logic [31:0] d);
    wr_t e;
    e.cyc = c; e.rd = r; e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_regwrite"},   32'(bus.regwrite),   32'd0);
    chk({tag, "_rd"},         32'(bus.rd),         32'd0);
    chk({tag, "_write_data"}, bus.write_data,      32'd0);
    chk({tag, "_fifo_count"}, 32'(bus.fifo_count), 32'd0);
    chk({tag, "_pend_mask"},  bus.pend_mask,       32'd0);
    chk({tag, "_mem_ready"},  32'(bus.mem_ready),  32'd1);
    chk({tag, "_alu_ready"},  32'(bus.alu_ready),  32'd1);
  endtask

  // Monitor: every asserted regwrite must match the oldest expected write.
  always @(negedge clk) begin
    if (bus.regwrite) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got rd=%0d data=%0h expected no write (cycle %0d)",
                 bus.rd, bus.write_data, cyc);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_cycle", cyc, e.cyc);
        chk("wr_rd", 32'(bus.rd), 32'(e.rd));
        chk("wr_data", bus.write_data, e.data);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish before 100000");
    $fatal(1, "timeout");
  end

  initial begin
    bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
    bus.mem_valid = 1'b0; bus.mem_rd = '0; bus.mem_data = '0;

    // Async reset acts before any clock edge
    #2 reset = 1'b1;
    #1 check_reset("rst_init");
    tick(); tick();
    reset = 1'b0;
    tick();

    // Single ALU write: visible at N+1 only
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'hDEADBEEF;
    chk("alu_ready_idle", 32'(bus.alu_ready), 32'd1);
    push(cyc + 1, 5'd5, 32'hDEADBEEF);
    tick();
    bus.alu_valid = 1'b0;
    chk("alu_wr_en", 32'(bus.regwrite), 32'd1);
    chk("alu_wr_rd", 32'(bus.rd), 32'd5);
    tick();
    chk("alu_wr_off", 32'(bus.regwrite), 32'd0);
    chk("alu_wr_hold_rd", 32'(bus.rd), 32'd5);

    // rd==0 results: handshakes complete, nothing written or buffered
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd0; bus.alu_data = 32'h1234;
    chk("alu_rd0_ready", 32'(bus.alu_ready), 32'd1);
    tick();
    bus.alu_valid = 1'b0;
    bus.mem_valid = 1'b1; bus.mem_rd = 5'd0; bus.mem_data = 32'h5678;
    chk("mem_rd0_ready", 32'(bus.mem_ready), 32'd1);
    tick();
    bus.mem_valid = 1'b0;
    chk("rd0_count", 32'(bus.fifo_count), 32'd0);
    tick(); tick();
    chk("rd0_count_late", 32'(bus.fifo_count), 32'd0);
    chk("rd0_pend", bus.pend_mask, 32'd0);

    // Fill FIFO with rd 1..4 under continuous ALU traffic
    for (int i = 0; i < 4; i++) begin
      bus.alu_valid = 1'b1; bus.alu_rd = 5'(10 + i); bus.alu_data = 32'hA0000000 + 32'(i);
      bus.mem_valid = 1'b1; bus.mem_rd = 5'(i + 1);  bus.mem_data = 32'hB0000001 + 32'(i);
      chk("fill_alu_ready", 32'(bus.alu_ready), 32'd1);
      chk("fill_mem_ready", 32'(bus.mem_ready), 32'd1);
      push(cyc + 1, 5'(10 + i), 32'hA0000000 + 32'(i));
      tick();
    end
    bus.mem_valid = 1'b0;
    bus.alu_rd = 5'd14; bus.alu_data = 32'hA0000004;
    chk("full_count", 32'(bus.fifo_count), 32'd4);
    chk("full_mem_ready", 32'(bus.mem_ready), 32'd0);
    chk("full_pend", bus.pend_mask, 32'h1E);
    chk("starved_alu_ready", 32'(bus.alu_ready), 32'd0);
    for (int i = 0; i < 4; i++) push(cyc + 1 + 32'(i), 5'(i + 1), 32'hB0000001 + 32'(i));
    tick();
    bus.alu_valid = 1'b0;
    chk("drain1_pend", bus.pend_mask, 32'h1C);
    chk("drain1_mem_ready", 32'(bus.mem_ready), 32'd1);
    chk("drain1_count", 32'(bus.fifo_count), 32'd3);
    tick();
    chk("drain2_pend", bus.pend_mask, 32'h18);
    tick();
    chk("drain3_pend", bus.pend_mask, 32'h10);
    tick();
    chk("drain4_pend", bus.pend_mask, 32'h0);
    chk("drain4_count", 32'(bus.fifo_count), 32'd0);
    tick();

    // Duplicate destination: bit 7 survives the first dequeue
    bus.mem_valid = 1'b1; bus.mem_rd = 5'd7; bus.mem_data = 32'hC0000001;
    push(cyc + 2, 5'd7, 32'hC0000001);
    tick();
    bus.mem_data = 32'hC0000002;
    tick();
    bus.mem_valid = 1'b0;
    chk("dup_count", 32'(bus.fifo_count), 32'd1);
    chk("dup_pend", bus.pend_mask, 32'h80);
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd9; bus.alu_data = 32'hD9;
    push(cyc + 1, 5'd9, 32'hD9);
    tick();
    bus.alu_valid = 1'b0;
    chk("dup_pend_held", bus.pend_mask, 32'h80);
    chk("dup_count_held", 32'(bus.fifo_count), 32'd1);

    // Reset mid-drain: remaining rd 7 entry must vanish without a write
    @(negedge clk);
    #1 reset = 1'b1;
    #1 check_reset("rst_drain");
    tick();
    check_reset("rst_held");
    reset = 1'b0;
    repeat (4) tick();
    chk("post_rst_count", 32'(bus.fifo_count), 32'd0);
    chk("post_rst_pend", bus.pend_mask, 32'd0);
    chk("post_rst_regwrite", 32'(bus.regwrite), 32'd0);

    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
